// File: rtl/eight_thirty_two_pkg.sv
// ============================================================================
// Module      : eight_thirty_two_pkg
// Description : Constants and types shared by both ends of the div_8_clk
//               byte link (32-to-8 framer and 8-to-32 deframer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eight_thirty_two_pkg;

    localparam logic [7:0]  DEFAULT_IDLE_BYTE  = 8'h00;
    localparam logic [3:0]  DEFAULT_HDR_NIBBLE = 4'hA;
    localparam logic [15:0] DEFAULT_TRAILER    = 16'hBEEF;

    localparam int FRAME_BYTES = 4;
    localparam int GAP_CYCLES  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/thirty_two_to_eight.sv
// ============================================================================
// Module      : thirty_two_to_eight
// Description : Transmit framer/serializer: 12-bit payload -> 4-byte frame
//               plus one idle gap byte. Optional macro TX_FRAME_CNT_EN adds
//               a 16-bit sent-frame counter output (frame_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module thirty_two_to_eight
    import eight_thirty_two_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE  = DEFAULT_IDLE_BYTE,
    parameter logic [3:0]  HDR_NIBBLE = DEFAULT_HDR_NIBBLE,
    parameter logic [15:0] TRAILER    = DEFAULT_TRAILER
) (
    input  logic        div_8_clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [11:0] s_data,
    output logic        s_ready,
    output logic [7:0]  data_out,
    output logic        tx_busy,
    output logic        tx_done
`ifdef TX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [31:0]      r_frame;
    logic [31:0]      w_frame_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_handshake;
    logic [7:0]       w_frame_byte;

    assign s_ready     = (r_state == IDLE) || (r_state == GAP);
    assign w_handshake = s_valid && s_ready;

    // Byte idx of the frame, MSB byte first (idx 0 -> bits 31:24)
    assign w_frame_byte = r_frame[{~r_idx, 3'b000} +: 8];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        w_data_nxt  = IDLE_BYTE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE, GAP: begin
                if (w_handshake) begin
                    w_frame_nxt = {HDR_NIBBLE, s_data, TRAILER};
                    w_data_nxt  = {HDR_NIBBLE, s_data[11:8]};
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                w_busy_nxt = 1'b1;
                // idx wraps to 0 after the last byte; that edge drives the gap byte
                if (r_idx == '0) begin
                    w_state_nxt = GAP;
                end else begin
                    w_data_nxt = w_frame_byte;
                    w_done_nxt = (r_idx == C_LAST_IDX);
                    w_idx_nxt  = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_frame  <= '0;
            data_out <= IDLE_BYTE;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_frame  <= w_frame_nxt;
            data_out <= w_data_nxt;
            tx_busy  <= w_busy_nxt;
            tx_done  <= w_done_nxt;
        end
    end

`ifdef TX_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (tx_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire
